// File: rtl/flex_down_timer_if.sv
// Control/status bundle for flex_down_timer.
// The master (testbench or parent block) drives the command inputs.
// The slave (the timer) returns the count and status.
interface flex_down_timer_if #(
  parameter int NUM_CNT_BITS = 5
);
  // Command signals. There is no valid/ready handshake on this bus:
  // - start is a single-cycle command, sampled on every rising edge it is
  //   high. A held level therefore acts as repeated starts.
  // - load_val and periodic are looked at only in a cycle where start=1.
  // - abort and count_enable are plain per-cycle levels.
  // - Priority within a cycle is abort > start > count_enable.
  logic                    start;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    periodic;
  logic                    count_enable;
  logic                    abort;

  // Status signals. All of them come straight from flops.
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    busy;
  logic                    done_flag;
  logic                    state_dbg;   // 1 while the FSM is in COUNT

  modport master (
    output start, load_val, periodic, count_enable, abort,
    input  count_out, busy, done_flag, state_dbg
  );

  modport slave (
    input  start, load_val, periodic, count_enable, abort,
    output count_out, busy, done_flag, state_dbg
  );
endinterface

// File: rtl/flex_down_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// A start command loads a count, and each count_enable tick decrements it.
// Reaching zero from one fires a registered one-cycle done pulse.
module flex_down_timer #(
  parameter int NUM_CNT_BITS = 5
) (
  input  logic               clk,
  input  logic               n_rst,
  flex_down_timer_if.slave   bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

  state_t                  state_q,    state_d;
  logic [NUM_CNT_BITS-1:0] count_q,    count_d;
  logic [NUM_CNT_BITS-1:0] reload_q,   reload_d;
  logic                    periodic_q, periodic_d;
  logic                    done_q,     done_d;
  logic                    busy_q,     busy_d;

  // A count of one that receives a tick is the expiry point. A count of zero
  // is never held in COUNT, but it is folded in here so the timer can never
  // wrap below zero.
  logic expiring;
  assign expiring = (count_q <= CNT_ONE);

  // Next-state logic. The if/else chain below encodes abort > start > tick.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;

    if (bus.abort) begin
      // Cancel the count silently. A start in the same cycle is dropped.
      state_d = ST_IDLE;
      count_d = CNT_ZERO;
    end else if (bus.start) begin
      if (bus.load_val != CNT_ZERO) begin
        // Load or restart. Any old count is discarded and gives no done pulse.
        reload_d   = bus.load_val;
        periodic_d = bus.periodic;
        count_d    = bus.load_val;
        state_d    = ST_COUNT;
      end else begin
        // A zero load expires at once. The mode latches are left as they are.
        done_d  = 1'b1;
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
      end
    end else if (state_q == ST_COUNT && bus.count_enable) begin
      if (!expiring) begin
        count_d = count_q - CNT_ONE;
      end else begin
        done_d = 1'b1;
        if (periodic_q) begin
          // Auto-reload, so the period is exactly reload_q ticks.
          count_d = reload_q;
          state_d = ST_COUNT;
        end else begin
          count_d = CNT_ZERO;
          state_d = ST_IDLE;
        end
      end
    end

    busy_d = (state_d == ST_COUNT);
  end

  // State, count and latch registers, cleared asynchronously by n_rst.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= CNT_ZERO;
      reload_q   <= CNT_ZERO;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.busy      = busy_q;
  assign bus.done_flag = done_q;
  assign bus.state_dbg = (state_q == ST_COUNT);

endmodule

// File: tb/tb_flex_down_timer.sv
// Bench for flex_down_timer: directed scenarios followed by random traffic.
// Every cycle is checked against a behavioural reference model.
module tb_flex_down_timer;
  localparam int W = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic n_rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  flex_down_timer_if #(.NUM_CNT_BITS(W)) bus ();

  flex_down_timer #(.NUM_CNT_BITS(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

  // Each entry packs {done, busy, count}.
  logic [W+1:0] exp_q[$];

  // Reference model. The timer is described here as a number of remaining
  // ticks plus a running flag, using plain integer arithmetic.
  bit m_run;
  int m_cnt;
  int m_reload;
  bit m_per;
  bit m_done;

  function automatic void model_reset();
    m_run    = 1'b0;
    m_cnt    = 0;
    m_reload = 0;
    m_per    = 1'b0;
    m_done   = 1'b0;
  endfunction

  function automatic void model_step(bit s, int lv, bit p, bit en, bit ab);
    m_done = 1'b0;
    if (ab) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (s && lv != 0) begin
      m_run    = 1'b1;
      m_cnt    = lv;
      m_reload = lv;
      m_per    = p;
    end else if (s) begin
      m_done = 1'b1;
      m_run  = 1'b0;
      m_cnt  = 0;
    end else if (m_run && en) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        if (m_per) m_cnt = m_reload;
        else       m_run = 1'b0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit s, input int lv, input bit p, input bit en, input bit ab);
    logic [W+1:0] e;
    bus.start        = s;
    bus.load_val     = W'(lv);
    bus.periodic     = p;
    bus.count_enable = en;
    bus.abort        = ab;
    @(posedge clk);
    model_step(s, lv, p, en, ab);
    exp_q.push_back({m_done, m_run, W'(m_cnt)});
    #1;
    e = exp_q.pop_front();
    check("count_out", 32'(bus.count_out), 32'(e[W-1:0]));
    check("busy",      32'(bus.busy),      32'(e[W]));
    check("done_flag", 32'(bus.done_flag), 32'(e[W+1]));
    if (bus.done_flag === 1'b1) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 0; bus.load_val = '0; bus.periodic = 0;
    bus.count_enable = 0; bus.abort = 0;
    n_rst = 1'b0;
    model_reset();
    #22;
    check("reset_count", 32'(bus.count_out), 0);
    check("reset_busy",  32'(bus.busy), 0);
    check("reset_done",  32'(bus.done_flag), 0);
    @(negedge clk);
    n_rst = 1'b1;
    idle(2);

    // One-shot, load 5, continuous enable: 5,4,3,2,1,0 with done on the 0.
    done_seen = 0;
    step(1, 5, 0, 1, 0);
    check("oneshot_load", 32'(bus.count_out), 5);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    check("oneshot_no_early_done", done_seen, 0);
    step(0, 0, 0, 1, 0);
    check("oneshot_done_at_5", done_seen, 1);
    check("oneshot_busy_fell", 32'(bus.busy), 0);
    step(0, 0, 0, 1, 0);
    idle(2);
    check("oneshot_single_pulse", done_seen, 1);

    // Periodic, load 3, 12 enabled cycles: four pulses and busy never drops.
    step(1, 3, 1, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) step(0, 9, 0, 1, 0);
    check("periodic_pulses", done_seen, 4);
    check("periodic_busy", 32'(bus.busy), 1);
    step(0, 0, 0, 0, 1);

    // Load 4 with enable toggling 1,0,1,0: done on the 4th tick only.
    step(1, 4, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, (i % 2) == 0, 0);
    check("toggle_pulses", done_seen, 1);

    // Restart mid-count: the first run gives no pulse.
    step(1, 6, 0, 0, 0);
    done_seen = 0;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("restart_pre", 32'(bus.count_out), 4);
    step(1, 2, 0, 1, 0);
    check("restart_load", 32'(bus.count_out), 2);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("restart_pulses", done_seen, 1);

    // Abort at count 3.
    step(1, 5, 0, 0, 0);
    done_seen = 0;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    idle(3);
    check("abort_no_done", done_seen, 0);

    // Abort and start together: the abort wins.
    step(1, 5, 0, 0, 0);
    step(1, 7, 1, 1, 1);
    check("abort_start_idle", 32'(bus.busy), 0);
    idle(2);

    // A zero load expires on the next cycle and busy stays low.
    done_seen = 0;
    step(1, 0, 1, 1, 0);
    check("zero_load_done", done_seen, 1);
    idle(2);
    check("zero_load_single", done_seen, 1);

    // Maximum load: done after 31 ticks.
    step(1, 31, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0);
    check("max_no_early", done_seen, 0);
    step(0, 0, 0, 1, 0);
    check("max_done", done_seen, 1);

    // Asynchronous reset pulsed mid-count.
    step(1, 9, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    #3;
    n_rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.count_out), 0);
    check("arst_busy",  32'(bus.busy), 0);
    check("arst_done",  32'(bus.done_flag), 0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    done_seen = 0;
    idle(3);
    check("arst_no_done_after", done_seen, 0);

    // Random traffic, including load_val/periodic noise outside start cycles.
    for (int i = 0; i < 500; i++) begin
      bit s;
      bit ab;
      int lv;
      s  = ($urandom_range(0, 9) == 0);
      ab = ($urandom_range(0, 29) == 0);
      lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 31);
      step(s, lv, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
